lc3_decode_stage: RTL and testbench

Synthesizable LC-3 decode stage: the consuming end of the decode_in interface (clock, reset, enable_decode, instr_dout, npc_in). It registers the fetched instruction and its next-PC on every enabled cycle. It also generates the registered execute, writeback and memory control words consumed by the execute/writeback/memstate stages. It is the DUT whose inputs the decode_in monitor samples.

---
 rtl/lc3_decode_stage.sv | 108 ++++++++++
 tb/tb_lc3_decode_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: registers instruction/next-PC and decodes execute, writeback and memory control words.
// Latency: one cycle from a capture edge to the outputs; no combinational input-to-output path.
// Backpressure: none; enable_decode low holds every output and drops decode_valid.
module lc3_decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] instr_dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
    output logic        decode_valid,
    output logic        illegal_op
);

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_ctrl_t;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_PC  = 2'b01;
    localparam logic [1:0] W_MEM = 2'b10;

    logic [3:0] opcode;
    e_ctrl_t    e_dec;
    logic [1:0] w_dec;
    logic       mem_dec;
    logic       ill_dec;

    assign opcode = instr_dout[15:12];

    always_comb begin
        e_dec   = '0;
        w_dec   = W_ALU;
        mem_dec = 1'b0;
        ill_dec = 1'b0;
        case (opcode)
            4'b0001: e_dec.op2select = instr_dout[5];
            4'b0101: begin
                e_dec.alu_control = 2'b01;
                e_dec.op2select   = instr_dout[5];
            end
            4'b1001: e_dec.alu_control = 2'b10;
            4'b0000, 4'b0011: begin
                e_dec.pcselect1 = 2'b01;
                e_dec.pcselect2 = 1'b1;
            end
            4'b0010: begin
                e_dec.pcselect1 = 2'b01;
                e_dec.pcselect2 = 1'b1;
                w_dec           = W_MEM;
            end
            4'b1010: begin
                e_dec.pcselect1 = 2'b01;
                e_dec.pcselect2 = 1'b1;
                w_dec           = W_MEM;
                mem_dec         = 1'b1;
            end
            4'b1011: begin
                e_dec.pcselect1 = 2'b01;
                e_dec.pcselect2 = 1'b1;
                mem_dec         = 1'b1;
            end
            4'b1110: begin
                e_dec.pcselect1 = 2'b01;
                e_dec.pcselect2 = 1'b1;
                w_dec           = W_PC;
            end
            4'b0110: begin
                e_dec.pcselect1 = 2'b10;
                w_dec           = W_MEM;
            end
            4'b0111: e_dec.pcselect1 = 2'b10;
            4'b1100: e_dec.pcselect1 = 2'b11;
            // JSR, RTI, reserved and TRAP are not handled by this pipeline
            default: ill_dec = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            IR           <= '0;
            npc_out      <= '0;
            E_Control    <= '0;
            W_Control    <= '0;
            Mem_Control  <= 1'b0;
            decode_valid <= 1'b0;
            illegal_op   <= 1'b0;
        end else if (enable_decode) begin
            IR           <= instr_dout;
            npc_out      <= npc_in;
            E_Control    <= e_dec;
            W_Control    <= w_dec;
            Mem_Control  <= mem_dec;
            decode_valid <= 1'b1;
            illegal_op   <= ill_dec;
        end else begin
            decode_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Directed vector table plus randomized traffic checked against a rule-level decode model.
module tb_lc3_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_decode;
    logic [15:0] instr_dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        decode_valid;
    logic        illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_decode_stage dut (
        .clock        (clock),
        .reset        (reset),
        .enable_decode(enable_decode),
        .instr_dout   (instr_dout),
        .npc_in       (npc_in),
        .IR           (IR),
        .npc_out      (npc_out),
        .E_Control    (E_Control),
        .W_Control    (W_Control),
        .Mem_Control  (Mem_Control),
        .decode_valid (decode_valid),
        .illegal_op   (illegal_op)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] instr;
        logic [15:0] npc;
        logic [15:0] ir;
        logic [15:0] npc_o;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        dv;
        logic        ill;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic [15:0] instr,
                                input logic [15:0] npc, input logic [15:0] ir,
                                input logic [15:0] npc_o, input logic [5:0] e,
                                input logic [1:0] w, input logic m, input logic dv,
                                input logic ill, input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.instr = instr; v.npc = npc;
        v.ir = ir; v.npc_o = npc_o; v.e = e; v.w = w; v.m = m; v.dv = dv; v.ill = ill;
        v.name = name;
        return v;
    endfunction

    // Decode rules stated per field, straight from the opcode groupings.
    // Returns {E_Control, W_Control, Mem_Control, illegal_op}.
    function automatic logic [9:0] model_decode(input logic [15:0] ins);
        logic [3:0] op;
        logic [1:0] alu, pcs1, w;
        logic       pcs2, op2, m;
        op = ins[15:12];
        if (op inside {4'h4, 4'h8, 4'hD, 4'hF}) return 10'b00_0000_00_0_1;
        alu  = (op == 4'h5) ? 2'd1 : (op == 4'h9) ? 2'd2 : 2'd0;
        pcs2 = op inside {4'h0, 4'h2, 4'hA, 4'hE, 4'h3, 4'hB};
        pcs1 = pcs2 ? 2'd1 : (op inside {4'h6, 4'h7}) ? 2'd2 : (op == 4'hC) ? 2'd3 : 2'd0;
        op2  = (op inside {4'h1, 4'h5}) && ins[5];
        w    = (op == 4'hE) ? 2'd1 : (op inside {4'h2, 4'h6, 4'hA}) ? 2'd2 : 2'd0;
        m    = op inside {4'hA, 4'hB};
        return {alu, pcs1, pcs2, op2, w, m, 1'b0};
    endfunction

    task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got IR=%h npc=%h E=%b W=%b M=%b dv=%b ill=%b, want IR=%h npc=%h E=%b W=%b M=%b dv=%b ill=%b",
                     name, act[42:27], act[26:11], act[10:5], act[4:3], act[2], act[1], act[0],
                     exp[42:27], exp[26:11], exp[10:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [42:0] dut_outs();
        return {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    endfunction

    logic [15:0] m_ir, m_npc;
    logic [9:0]  m_ctl;
    logic        m_dv;

    initial begin
        reset = 1'b1; enable_decode = 1'b1; instr_dout = 16'h12A3; npc_in = 16'h3001;

        vecs.push_back(mk(1,1,16'h12A3,16'h3001, 16'h0000,16'h0000,6'h00,2'd0,0,0,0,"reset1"));
        vecs.push_back(mk(1,1,16'h12A3,16'h3001, 16'h0000,16'h0000,6'h00,2'd0,0,0,0,"reset2"));
        vecs.push_back(mk(0,1,16'h12A3,16'h3001, 16'h12A3,16'h3001,6'h01,2'd0,0,1,0,"add_imm"));
        vecs.push_back(mk(0,1,16'h6702,16'h3002, 16'h6702,16'h3002,6'h08,2'd2,0,1,0,"ldr"));
        vecs.push_back(mk(0,1,16'hA5FF,16'h3003, 16'hA5FF,16'h3003,6'h06,2'd2,1,1,0,"ldi_b2b"));
        vecs.push_back(mk(0,1,16'hE3F0,16'h3004, 16'hE3F0,16'h3004,6'h06,2'd1,0,1,0,"lea"));
        vecs.push_back(mk(0,0,16'hFFFF,16'h1111, 16'hE3F0,16'h3004,6'h06,2'd1,0,0,0,"hold1"));
        vecs.push_back(mk(0,0,16'h0000,16'h2222, 16'hE3F0,16'h3004,6'h06,2'd1,0,0,0,"hold2"));
        vecs.push_back(mk(0,0,16'hD123,16'h3333, 16'hE3F0,16'h3004,6'h06,2'd1,0,0,0,"hold3"));
        vecs.push_back(mk(0,0,16'h5A5A,16'h4444, 16'hE3F0,16'h3004,6'h06,2'd1,0,0,0,"hold4"));
        vecs.push_back(mk(0,0,16'hA5A5,16'h5555, 16'hE3F0,16'h3004,6'h06,2'd1,0,0,0,"hold5"));
        vecs.push_back(mk(0,1,16'hD123,16'h3005, 16'hD123,16'h3005,6'h00,2'd0,0,1,1,"illegal_d"));
        vecs.push_back(mk(0,1,16'h5000,16'h3006, 16'h5000,16'h3006,6'h10,2'd0,0,1,0,"and_clears"));
        vecs.push_back(mk(1,1,16'h0E05,16'h3007, 16'h0000,16'h0000,6'h00,2'd0,0,0,0,"reset_mid"));
        vecs.push_back(mk(0,1,16'h0E05,16'h3007, 16'h0E05,16'h3007,6'h06,2'd0,0,1,0,"br_after_rst"));
        vecs.push_back(mk(0,0,16'hxxxx,16'hxxxx, 16'h0E05,16'h3007,6'h06,2'd0,0,0,0,"x_hold"));
        vecs.push_back(mk(0,1,16'h9A3F,16'h3008, 16'h9A3F,16'h3008,6'h20,2'd0,0,1,0,"not"));
        vecs.push_back(mk(0,1,16'hC1C0,16'h3009, 16'hC1C0,16'h3009,6'h0C,2'd0,0,1,0,"jmp"));
        vecs.push_back(mk(0,1,16'h7285,16'h300A, 16'h7285,16'h300A,6'h08,2'd0,0,1,0,"str"));
        vecs.push_back(mk(0,1,16'h3410,16'h300B, 16'h3410,16'h300B,6'h06,2'd0,0,1,0,"st"));
        vecs.push_back(mk(0,1,16'hB410,16'h300C, 16'hB410,16'h300C,6'h06,2'd0,1,1,0,"sti"));
        vecs.push_back(mk(0,1,16'h2410,16'h300D, 16'h2410,16'h300D,6'h06,2'd2,0,1,0,"ld"));
        vecs.push_back(mk(0,1,16'h1042,16'h300E, 16'h1042,16'h300E,6'h00,2'd0,0,1,0,"add_reg"));
        vecs.push_back(mk(0,1,16'h5260,16'h300F, 16'h5260,16'h300F,6'h11,2'd0,0,1,0,"and_imm"));
        vecs.push_back(mk(0,1,16'h4800,16'h3010, 16'h4800,16'h3010,6'h00,2'd0,0,1,1,"jsr_illegal"));
        vecs.push_back(mk(0,1,16'h8000,16'h3011, 16'h8000,16'h3011,6'h00,2'd0,0,1,1,"rti_illegal"));
        vecs.push_back(mk(0,1,16'hF025,16'h3012, 16'hF025,16'h3012,6'h00,2'd0,0,1,1,"trap_illegal"));

        foreach (vecs[i]) begin
            reset = vecs[i].rst; enable_decode = vecs[i].en;
            instr_dout = vecs[i].instr; npc_in = vecs[i].npc;
            @(posedge clock); #1;
            check(vecs[i].name, dut_outs(),
                  {vecs[i].ir, vecs[i].npc_o, vecs[i].e, vecs[i].w, vecs[i].m, vecs[i].dv, vecs[i].ill});
        end

        // Randomized traffic: model carries held state between captures.
        m_ir  = IR;
        m_npc = npc_out;
        m_ctl = {E_Control, W_Control, Mem_Control, illegal_op};
        m_dv  = decode_valid;
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 15) == 0);
            enable_decode = 1'($urandom_range(0, 2) != 0);
            instr_dout    = 16'($urandom);
            npc_in        = 16'($urandom);
            @(posedge clock); #1;
            if (reset) begin
                m_ir = '0; m_npc = '0; m_ctl = '0; m_dv = 1'b0;
            end else if (enable_decode) begin
                m_ir = instr_dout; m_npc = npc_in; m_ctl = model_decode(instr_dout); m_dv = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            check("random", dut_outs(), {m_ir, m_npc, m_ctl[9:1], m_dv, m_ctl[0]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
